// File: rtl/freq_pkg.sv
// Shared types for the clock-mode scheduler: the 2-bit mode type, the named
// clock sources and the FSM state encoding.
package freq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SRC1 = 2'd0;
    localparam mode_t MODE_SRC2 = 2'd1;
    localparam mode_t MODE_SRC3 = 2'd2;
    localparam mode_t MODE_SRC4 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/freq_req_pick.sv
// Combinational arbiter: highest requested mode among active requesters,
// ties to the lowest index, mode 0 / winner 0 when nobody is asking.
module freq_req_pick
    import freq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]   req_vld,
    input  logic [2*NREQ-1:0] req_mode,
    output mode_t             target,
    output logic [1:0]        winner
);

    logic found;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        target = MODE_SRC1;
        winner = 2'd0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // Strict '>' keeps the lowest index on a tie.
            if (req_vld[i] && (!found || mode_t'(req_mode[2*i +: 2]) > target)) begin
                target = mode_t'(req_mode[2*i +: 2]);
                winner = 2'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_sched.sv
// Clock-mode scheduler: requests a clock switch, waits for the ack, then holds
// the new mode for DWELL_CYC cycles. Define FREQ_SCHED_TIMEOUT_EN for the ack timeout.
module freq_sched
    import freq_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DWELL_CYC   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic              sw_ack,
    input  logic              err_clr,
    output logic              sw_req,
    output logic [1:0]        sw_mode,
    output logic [1:0]        cur_mode,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              err
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    mode_t       target;
    logic [1:0]  winner;

    state_t      state_q,     state_d;
    logic        sw_req_q,    sw_req_d;
    mode_t       sw_mode_q,   sw_mode_d;
    mode_t       cur_mode_q,  cur_mode_d;
    logic [1:0]  grant_id_q,  grant_id_d;
    logic        busy_q,      busy_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

    freq_req_pick #(.NREQ(NREQ)) u_pick (
        .req_vld  (req_vld),
        .req_mode (req_mode),
        .target   (target),
        .winner   (winner)
    );

`ifdef FREQ_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic          tmo_hit;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_comb begin
        state_d     = state_q;
        sw_req_d    = sw_req_q;
        sw_mode_d   = sw_mode_q;
        cur_mode_d  = cur_mode_q;
        grant_id_d  = grant_id_q;
        dwell_cnt_d = dwell_cnt_q;
`ifdef FREQ_SCHED_TIMEOUT_EN
        tmo_cnt_d   = '0;
        tmo_hit     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (target != cur_mode_q) begin
                    state_d    = ST_REQ;
                    sw_req_d   = 1'b1;
                    sw_mode_d  = target;
                    grant_id_d = winner;
                end
            end
            ST_REQ: begin
                // Arbiter output is deliberately ignored until the dwell is over.
                if (sw_ack) begin
                    cur_mode_d  = sw_mode_q;
                    sw_req_d    = 1'b0;
                    state_d     = ST_DWELL;
                    dwell_cnt_d = DW'(DWELL_CYC - 1);
                end
`ifdef FREQ_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_hit     = 1'b1;
                    sw_req_d    = 1'b0;
                    state_d     = ST_DWELL;
                    dwell_cnt_d = DW'(DWELL_CYC - 1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_DWELL: begin
                if (dwell_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifdef FREQ_SCHED_TIMEOUT_EN
    // A timeout in the same cycle as err_clr leaves err set.
    always_comb begin
        err_d = err_clr ? 1'b0 : err_q;
        if (tmo_hit) begin
            err_d = 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sw_req_q    <= 1'b0;
            sw_mode_q   <= MODE_SRC1;
            cur_mode_q  <= MODE_SRC1;
            grant_id_q  <= 2'd0;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
`ifdef FREQ_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sw_req_q    <= sw_req_d;
            sw_mode_q   <= sw_mode_d;
            cur_mode_q  <= cur_mode_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
            dwell_cnt_q <= dwell_cnt_d;
`ifdef FREQ_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign sw_req   = sw_req_q;
    assign sw_mode  = sw_mode_q;
    assign cur_mode = cur_mode_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
`ifdef FREQ_SCHED_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: doc/freq_sched.md
FREQ_SCHED -- requirements
Module: freq_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter DWELL_CYC, default 16: minimum cycles a newly applied mode is held before another switch.
REQ-003 Parameter TIMEOUT_CYC, default 64: cycles to wait for sw_ack before abandoning a switch.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_vld, input, NREQ: per-requester "mode request active".
REQ-007 Port req_mode, input, 2*NREQ: requested clock mode, requester i at bits [2i+1:2i].
REQ-008 Port sw_ack, input, 1: clock switch done with sw_mode.
REQ-009 Port err_clr, input, 1: clears err.
REQ-010 Port sw_req, output, 1: switch request to clock switch.
REQ-011 Port sw_mode, output, 2: mode presented with sw_req.
REQ-012 Port cur_mode, output, 2: mode currently applied.
REQ-013 Port grant_id, output, 2: requester whose mode was last applied.
REQ-014 Port busy, output, 1: high whenever state is not IDLE.
REQ-015 Port err, output, 1: sticky ack-timeout flag.

Function
REQ-016 Target = maximum req_mode among requesters with req_vld=1; ties to lowest index; target=2'b00 and winner 0 when req_vld is all zero.
REQ-017 FSM states SHALL be IDLE, REQ, DWELL; all outputs registered.
REQ-018 IDLE: when target != cur_mode, next edge enters REQ, sets sw_req=1, latches sw_mode=target, grant_id=winner; otherwise stays IDLE.
REQ-019 REQ: sw_req and sw_mode stable until sw_ack sampled 1; target changes during REQ and DWELL are ignored.
REQ-020 On edge with sw_ack=1 in REQ: cur_mode<=sw_mode, sw_req<=0, enter DWELL, dwell counter loaded DWELL_CYC-1.
REQ-021 DWELL: counter decrements each cycle; at 0 the next edge enters IDLE; DWELL lasts exactly DWELL_CYC cycles.
REQ-022 sw_ack in IDLE or DWELL is ignored.
REQ-023 Target re-evaluated in IDLE the cycle DWELL ends; a still-differing target re-enters REQ one edge later.
REQ-024 err_clr=1 clears err next edge; a simultaneous timeout event wins (err=1).
REQ-025 Minimum request-to-sw_req latency: one edge.

Reset
REQ-026 rstn=0 asynchronously forces state=IDLE, sw_req=0, sw_mode=0, cur_mode=0, grant_id=0, busy=0, err=0, counters=0.
REQ-027 Reset mid-REQ or mid-DWELL abandons the switch; cur_mode returns to 0 (clock switch reset to source 1 in parallel).

Configuration
REQ-028 Macro FREQ_SCHED_TIMEOUT_EN defined: REQ counts cycles; after TIMEOUT_CYC cycles without sw_ack, sw_req<=0, err<=1, cur_mode unchanged, enter DWELL.
REQ-029 Macro undefined: REQ waits indefinitely for sw_ack; err constant 0; err_clr unused; no timeout counter.

Structure
REQ-030 Shared package freq_pkg SHALL hold the mode type (2-bit), mode constants MODE_SRC1..MODE_SRC4 (0..3), and FSM state encoding.
REQ-031 Sub-module freq_req_pick SHALL implement combinational target/winner selection (REQ-016); FSM, counters in freq_sched.

Verification
REQ-032 Reset release, req_vld=0 -> stays IDLE, sw_req=0, cur_mode=0 indefinitely.
REQ-033 req_vld=4'b0001, req0 mode 2 -> sw_req=1, sw_mode=2 one edge later; ack after 3 cycles -> cur_mode=2, grant_id=0, busy=1 for 16 more cycles.
REQ-034 req0 mode 1, req2 mode 3, req3 mode 3 -> sw_mode=3, grant_id=2.
REQ-035 During DWELL, req changes to mode 0 -> no sw_req until DWELL ends, then sw_req with sw_mode=0 one edge after IDLE.
REQ-036 FREQ_SCHED_TIMEOUT_EN, no ack -> sw_req drops after 64 cycles, err=1, cur_mode unchanged; err_clr pulse -> err=0.
REQ-037 rstn asserted mid-REQ -> all outputs 0 immediately, no clock edge required.
